// File: rtl/voice_sequencer_pkg.sv
// Shared types and constants for the voice sequencer: FSM state encodings,
// waveform address width, default sizes and the accumulator width helper.
package voice_sequencer_pkg;

  localparam int WAVE_ADDR_W  = 8;
  localparam int NVOICE_DEF   = 4;
  localparam int PHASE_W_DEF  = 16;
  localparam int SAMPLE_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_HOLD   = 3'd5
  } seq_state_e;

  // Headroom for summing nvoice full-scale samples without overflow.
  function automatic int acc_width(input int nvoice, input int sample_w);
    return sample_w + $clog2(nvoice);
  endfunction

endpackage

// File: rtl/voice_sequencer_if.sv
// Bus bundle between the voice sequencer (master) and its environment:
// config writes, frame strobe, waveform lookup and mixed-sample handshake.
interface voice_sequencer_if
  import voice_sequencer_pkg::*;
#(
  parameter int NVOICE   = NVOICE_DEF,
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
);
  localparam int VOICE_W = $clog2(NVOICE);

  logic                   sample_tick;
  logic                   cfg_we;
  logic [VOICE_W-1:0]     cfg_voice;
  logic [PHASE_W-1:0]     cfg_inc;
  logic                   cfg_gate;
  logic                   wave_req;
  logic [WAVE_ADDR_W-1:0] wave_phase;
  logic [SAMPLE_W-1:0]    wave_sample;
  logic                   wave_valid;
  logic [SAMPLE_W-1:0]    mix_out;
  logic                   mix_valid;
  logic                   mix_ready;
  logic                   busy;
  logic                   overrun;

  modport master (
    input  sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate,
    input  wave_sample, wave_valid, mix_ready,
    output wave_req, wave_phase, mix_out, mix_valid, busy, overrun
  );

  modport slave (
    output sample_tick, cfg_we, cfg_voice, cfg_inc, cfg_gate,
    output wave_sample, wave_valid, mix_ready,
    input  wave_req, wave_phase, mix_out, mix_valid, busy, overrun
  );

endinterface

// File: rtl/voice_mix_sat.sv
// Reduces the wide signed voice accumulator to one output sample.
// VOICE_SEQ_SATURATE_EN selects clamping; otherwise the low bits wrap.
module voice_mix_sat #(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 10
) (
  input  logic [ACC_W-1:0]    acc_i,
  output logic [SAMPLE_W-1:0] mix_o
);

`ifdef VOICE_SEQ_SATURATE_EN
  // Out of range when the bits above the output sign are not a pure sign extension.
  always_comb begin
    mix_o = acc_i[SAMPLE_W-1:0];
    if (acc_i[ACC_W-1:SAMPLE_W-1] != {(ACC_W-SAMPLE_W+1){acc_i[ACC_W-1]}}) begin
      if (acc_i[ACC_W-1]) begin
        mix_o = {1'b1, {(SAMPLE_W-1){1'b0}}};
      end else begin
        mix_o = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
    end else begin
      mix_o = acc_i[SAMPLE_W-1:0];
    end
  end
`else
  logic unused_hi_s;

  // Two's-complement wrap: only the low sample bits survive.
  always_comb begin
    mix_o = acc_i[SAMPLE_W-1:0];
  end

  assign unused_hi_s = ^acc_i[ACC_W-1:SAMPLE_W];
`endif

endmodule

// File: rtl/voice_sequencer.sv
// Time-multiplexes one waveform lookup across NVOICE phase-accumulator voices
// and mixes them once per frame. Output reduction honours VOICE_SEQ_SATURATE_EN.
module voice_sequencer
  import voice_sequencer_pkg::*;
#(
  parameter int NVOICE   = NVOICE_DEF,
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input logic               clk,
  input logic               rst,
  voice_sequencer_if.master bus
);

  localparam int VOICE_W = $clog2(NVOICE);
  localparam int ACC_W   = acc_width(NVOICE, SAMPLE_W);
  localparam logic [VOICE_W-1:0] LAST_V = VOICE_W'(NVOICE - 1);
  localparam logic [VOICE_W-1:0] ONE_V  = VOICE_W'(1'b1);

  seq_state_e             state_q;
  logic [VOICE_W-1:0]     v_q;
  logic [ACC_W-1:0]       acc_q;
  logic [PHASE_W-1:0]     phase_q [NVOICE];
  logic [PHASE_W-1:0]     inc_q   [NVOICE];
  logic [NVOICE-1:0]      gate_q;
  logic                   wave_req_q;
  logic [WAVE_ADDR_W-1:0] wave_phase_q;
  logic [SAMPLE_W-1:0]    mix_out_q;
  logic                   mix_valid_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [SAMPLE_W-1:0]    mix_out_d;
  logic [ACC_W-1:0]       sample_sext_d;

  assign sample_sext_d = {{(ACC_W-SAMPLE_W){bus.wave_sample[SAMPLE_W-1]}}, bus.wave_sample};

  voice_mix_sat #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_mix_sat (
    .acc_i (acc_q),
    .mix_o (mix_out_d)
  );

  // Config register file: writes land on the next edge regardless of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NVOICE; i++) begin
        inc_q[i] <= '0;
      end
      gate_q <= '0;
    end else if (bus.cfg_we) begin
      inc_q[bus.cfg_voice]  <= bus.cfg_inc;
      gate_q[bus.cfg_voice] <= bus.cfg_gate;
    end
  end

  // Frame FSM; owns the phase accumulators so a same-cycle config write never races the step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      v_q          <= '0;
      acc_q        <= '0;
      for (int i = 0; i < NVOICE; i++) begin
        phase_q[i] <= '0;
      end
      wave_req_q   <= 1'b0;
      wave_phase_q <= '0;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wave_req_q <= 1'b0;
      if (bus.sample_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.sample_tick) begin
            v_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (gate_q[v_q]) begin
            wave_req_q   <= 1'b1;
            wave_phase_q <= phase_q[v_q][PHASE_W-1 -: WAVE_ADDR_W];
            state_q      <= ST_WAIT;
          end else begin
            phase_q[v_q] <= '0;
            state_q      <= ST_NEXT;
          end
        end
        ST_WAIT: begin
          if (bus.wave_valid) begin
            acc_q        <= acc_q + sample_sext_d;
            phase_q[v_q] <= phase_q[v_q] + inc_q[v_q];
            state_q      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (v_q == LAST_V) begin
            state_q <= ST_OUTPUT;
          end else begin
            v_q     <= v_q + ONE_V;
            state_q <= ST_ISSUE;
          end
        end
        ST_OUTPUT: begin
          mix_out_q   <= mix_out_d;
          mix_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.mix_ready) begin
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          mix_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wave_req   = wave_req_q;
  assign bus.wave_phase = wave_phase_q;
  assign bus.mix_out    = mix_out_q;
  assign bus.mix_valid  = mix_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule
